xrs_wb_arb: RTL and testbench

Write-back arbiter and load scoreboard for the `xrs` register file (32 × 64-bit, two registered read ports, one write port, x0 hardwired to zero). It shares the single `xrs` write port between the execute unit and the load unit using valid/ready handshakes. It also tracks which registers have an outstanding load, so decode can stall on read-after-load hazards. It sits between the execute/load pipeline stages and `xrs`, and drives `rd_i`/`rdat_i`/`rwe_i` of `xrs` directly.

---
 rtl/xrs_pkg.sv | 17 +
 rtl/xrs_scoreboard.sv | 47 ++++
 rtl/xrs_wb_arb.sv | 126 ++++++++++++
 tb/tb_xrs_wb_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/xrs_pkg.sv
// Shared types and constants for the xrs register file and its write-back arbiter.
package xrs_pkg;

  localparam int XRS_NREGS = 32;
  localparam int XRS_AW    = 5;
  localparam int XRS_XLEN  = 64;

  typedef enum logic {
    WB_EX = 1'b0,
    WB_LD = 1'b1
  } wb_src_t;

  function automatic logic is_x0(input logic [XRS_AW-1:0] r);
    return (r == {XRS_AW{1'b0}});
  endfunction

endpackage

// File: rtl/xrs_scoreboard.sv
// Pending-load scoreboard: one bit per register, x0 never pending, two-port hazard lookup.
module xrs_scoreboard
  import xrs_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              set_en_i,
  input  logic [XRS_AW-1:0] set_rd_i,
  input  logic              clr_en_i,
  input  logic [XRS_AW-1:0] clr_rd_i,
  input  logic [XRS_AW-1:0] ra_i,
  input  logic [XRS_AW-1:0] rb_i,
  output logic              hazard_o
);

  logic [XRS_NREGS-1:1] pend_r;
  logic [XRS_NREGS-1:1] pend_nxt_s;
  logic [XRS_NREGS-1:0] pend_full_s;

  // Next pending vector: clear first so a same-cycle set of the same bit wins.
  always_comb begin
    pend_nxt_s = pend_r;
    if (clr_en_i && !is_x0(clr_rd_i)) begin
      pend_nxt_s[clr_rd_i] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (set_en_i && !is_x0(set_rd_i)) begin
      pend_nxt_s[set_rd_i] = 1'b1;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
  end

  // Pending-bit storage.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      pend_r <= {(XRS_NREGS-1){1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  assign pend_full_s = {pend_r, 1'b0};
  assign hazard_o    = pend_full_s[ra_i] | pend_full_s[rb_i];

endmodule

// File: rtl/xrs_wb_arb.sv
// Write-back arbiter for the xrs write port plus load scoreboard.
// Build option: XRS_WB_RR_EN selects round-robin contention; otherwise load has fixed priority.
module xrs_wb_arb
  import xrs_pkg::*;
#(
  parameter int XLEN = XRS_XLEN
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [XRS_AW-1:0] ex_rd_i,
  input  logic [XLEN-1:0]   ex_dat_i,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [XRS_AW-1:0] ld_rd_i,
  input  logic [XLEN-1:0]   ld_dat_i,
  input  logic              ld_issue_i,
  input  logic [XRS_AW-1:0] ld_issue_rd_i,
  input  logic [XRS_AW-1:0] ra_i,
  input  logic [XRS_AW-1:0] rb_i,
  output logic              hazard_o,
  output logic [XRS_AW-1:0] rd_o,
  output logic [XLEN-1:0]   rdat_o,
  output logic              rwe_o
);

  logic              ex_gnt_s;
  logic              ld_gnt_s;
  logic              xfer_s;
  logic [XRS_AW-1:0] win_rd_s;
  logic [XLEN-1:0]   win_dat_s;
  logic [XRS_AW-1:0] rd_r;
  logic [XLEN-1:0]   rdat_r;
  logic              rwe_r;
  wb_src_t           wb_ld_r;
`ifdef XRS_WB_RR_EN
  logic              last_ld_r;
`endif

  // Grant selection; the two grants are never asserted together.
  always_comb begin
    ex_gnt_s = 1'b0;
    ld_gnt_s = 1'b0;
    if (ex_valid_i && ld_valid_i) begin
`ifdef XRS_WB_RR_EN
      ld_gnt_s = !last_ld_r;
      ex_gnt_s = last_ld_r;
`else
      ld_gnt_s = 1'b1;
`endif
    end else if (ld_valid_i) begin
      ld_gnt_s = 1'b1;
    end else if (ex_valid_i) begin
      ex_gnt_s = 1'b1;
    end else begin
      ex_gnt_s = 1'b0;
      ld_gnt_s = 1'b0;
    end
  end

  // Winner payload mux.
  always_comb begin
    win_rd_s  = ex_rd_i;
    win_dat_s = ex_dat_i;
    if (ld_gnt_s) begin
      win_rd_s  = ld_rd_i;
      win_dat_s = ld_dat_i;
    end else begin
      win_rd_s  = ex_rd_i;
      win_dat_s = ex_dat_i;
    end
  end

  assign xfer_s     = ex_gnt_s | ld_gnt_s;
  assign ex_ready_o = ex_gnt_s;
  assign ld_ready_o = ld_gnt_s;

  // Write register toward xrs; x0 targets are accepted but never raise the write enable.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_r    <= {XRS_AW{1'b0}};
      rdat_r  <= {XLEN{1'b0}};
      rwe_r   <= 1'b0;
      wb_ld_r <= WB_EX;
    end else if (xfer_s) begin
      rd_r    <= win_rd_s;
      rdat_r  <= win_dat_s;
      rwe_r   <= !is_x0(win_rd_s);
      wb_ld_r <= ld_gnt_s ? WB_LD : WB_EX;
    end else begin
      rwe_r   <= 1'b0;
    end
  end

`ifdef XRS_WB_RR_EN
  // Round-robin history, advanced only when something is accepted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_ld_r <= 1'b0;
    end else if (xfer_s) begin
      last_ld_r <= ld_gnt_s;
    end else begin
      last_ld_r <= last_ld_r;
    end
  end
`endif

  assign rd_o   = rd_r;
  assign rdat_o = rdat_r;
  assign rwe_o  = rwe_r;

  // Pending bits clear on the edge that commits the load into xrs.
  xrs_scoreboard u_sb (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .set_en_i (ld_issue_i),
    .set_rd_i (ld_issue_rd_i),
    .clr_en_i (rwe_r && (wb_ld_r == WB_LD)),
    .clr_rd_i (rd_r),
    .ra_i     (ra_i),
    .rb_i     (rb_i),
    .hazard_o (hazard_o)
  );

endmodule

// File: tb/tb_xrs_wb_arb.sv
// Self-checking bench for xrs_wb_arb: per-cycle reference model plus directed literal checks.
module tb_xrs_wb_arb;

  logic        clk;
  logic        reset_ni;
  logic        ex_valid_i, ld_valid_i, ld_issue_i;
  logic        ex_ready_o, ld_ready_o, hazard_o, rwe_o;
  logic [4:0]  ex_rd_i, ld_rd_i, ld_issue_rd_i, ra_i, rb_i, rd_o;
  logic [63:0] ex_dat_i, ld_dat_i, rdat_o;

  int checks = 0;
  int errors = 0;

  // Reference state: what the write port and pending set must look like after the coming edge.
  logic [31:0] m_pend;
  logic        m_last_ld;
  logic        m_rwe;
  logic        m_wb_ld;
  logic [4:0]  m_rd;
  logic [63:0] m_rdat;
  logic [63:0] m_regs [32];

  logic        gl [4];
  logic        ge [4];
  logic [4:0]  grd [4];

  xrs_wb_arb #(.XLEN(64)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_rd_i(ex_rd_i), .ex_dat_i(ex_dat_i),
    .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i), .ld_dat_i(ld_dat_i),
    .ld_issue_i(ld_issue_i), .ld_issue_rd_i(ld_issue_rd_i),
    .ra_i(ra_i), .rb_i(rb_i), .hazard_o(hazard_o),
    .rd_o(rd_o), .rdat_o(rdat_o), .rwe_o(rwe_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Reference model: check outputs mid-cycle, then advance the model across the next rising edge.
  always @(negedge clk) begin : model
    logic want_ld, want_ex, go_ld, go_ex;
    want_ld = ld_valid_i;
    want_ex = ex_valid_i;
    if (want_ld && want_ex) begin
`ifdef XRS_WB_RR_EN
      go_ld = (m_last_ld == 1'b0);
`else
      go_ld = 1'b1;
`endif
    end else begin
      go_ld = want_ld;
    end
    go_ex = want_ex && !go_ld;
    if (!reset_ni) begin
      m_pend = 32'd0; m_last_ld = 1'b0; m_rwe = 1'b0; m_wb_ld = 1'b0;
      m_rd = 5'd0; m_rdat = 64'd0;
      chk("rst_rwe", {63'd0, rwe_o}, 64'd0);
      chk("rst_rd", {59'd0, rd_o}, 64'd0);
      chk("rst_rdat", rdat_o, 64'd0);
      chk("rst_hazard", {63'd0, hazard_o}, 64'd0);
      chk("rst_ld_ready", {63'd0, ld_ready_o}, {63'd0, want_ld});
      chk("rst_ex_ready", {63'd0, ex_ready_o}, {63'd0, want_ex && !want_ld});
    end else begin
      chk("m_ex_ready", {63'd0, ex_ready_o}, {63'd0, go_ex});
      chk("m_ld_ready", {63'd0, ld_ready_o}, {63'd0, go_ld});
      chk("m_hazard", {63'd0, hazard_o}, {63'd0, m_pend[ra_i] | m_pend[rb_i]});
      chk("m_rwe", {63'd0, rwe_o}, {63'd0, m_rwe});
      chk("m_rd", {59'd0, rd_o}, {59'd0, m_rd});
      chk("m_rdat", rdat_o, m_rdat);
      if (m_rwe) begin
        m_regs[m_rd] = m_rdat;
        if (m_wb_ld) m_pend[m_rd] = 1'b0;
      end
      if (ld_issue_i && ld_issue_rd_i != 5'd0) m_pend[ld_issue_rd_i] = 1'b1;
      if (go_ld || go_ex) begin
        m_rd      = go_ld ? ld_rd_i : ex_rd_i;
        m_rdat    = go_ld ? ld_dat_i : ex_dat_i;
        m_rwe     = (m_rd != 5'd0);
        m_wb_ld   = go_ld;
        m_last_ld = go_ld;
      end else begin
        m_rwe = 1'b0;
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    reset_ni = 1'b0;
    ex_valid_i = 1'b0; ld_valid_i = 1'b0; ld_issue_i = 1'b0;
    ex_rd_i = 5'd0; ld_rd_i = 5'd0; ld_issue_rd_i = 5'd0; ra_i = 5'd0; rb_i = 5'd0;
    ex_dat_i = 64'd0; ld_dat_i = 64'd0;

    // Reset: grants still follow the inputs.
    sample();
    ex_valid_i = 1'b1;
    #1;
    chk("rst_comb_ex_ready", {63'd0, ex_ready_o}, 64'd1);
    chk("rst_rwe_lit", {63'd0, rwe_o}, 64'd0);
    ex_valid_i = 1'b0;
    step();
    reset_ni = 1'b1;

    // Single requester.
    ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_dat_i = 64'h1122334455667788;
    sample();
    chk("single_ex_ready", {63'd0, ex_ready_o}, 64'd1);
    step();
    ex_valid_i = 1'b0;
    sample();
    chk("single_rwe", {63'd0, rwe_o}, 64'd1);
    chk("single_rd", {59'd0, rd_o}, 64'd3);
    chk("single_rdat", rdat_o, 64'h1122334455667788);
    chk("single_readback_x3", m_regs[3], 64'h1122334455667788);

    // Contention for four cycles.
    step();
    ex_valid_i = 1'b1; ex_rd_i = 5'd1; ex_dat_i = 64'hAAAA0000AAAA0001;
    ld_valid_i = 1'b1; ld_rd_i = 5'd2; ld_dat_i = 64'hBBBB0000BBBB0002;
    for (int i = 0; i < 4; i++) begin
      sample();
      gl[i] = ld_ready_o;
      ge[i] = ex_ready_o;
      if (i > 0) grd[i-1] = rd_o;
      step();
    end
    ex_valid_i = 1'b0; ld_valid_i = 1'b0;
    sample();
    grd[3] = rd_o;
    for (int i = 0; i < 4; i++) begin
`ifdef XRS_WB_RR_EN
      chk("rr_ld_ready", {63'd0, gl[i]}, (i % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_ex_ready", {63'd0, ge[i]}, (i % 2 == 0) ? 64'd0 : 64'd1);
      chk("rr_rd_seq", {59'd0, grd[i]}, (i % 2 == 0) ? 64'd2 : 64'd1);
`else
      chk("fix_ld_ready", {63'd0, gl[i]}, 64'd1);
      chk("fix_ex_ready", {63'd0, ge[i]}, 64'd0);
      chk("fix_rd_seq", {59'd0, grd[i]}, 64'd2);
`endif
    end

    // Load hazard and its clear timing.
    step();
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd5; ra_i = 5'd5;
    step();
    ld_issue_i = 1'b0;
    sample();
    chk("haz_set", {63'd0, hazard_o}, 64'd1);
    step();
    ld_valid_i = 1'b1; ld_rd_i = 5'd5; ld_dat_i = 64'h7766554433221100;
    sample();
    chk("haz_ld_ready", {63'd0, ld_ready_o}, 64'd1);
    step();
    ld_valid_i = 1'b0;
    sample();
    chk("haz_n1", {63'd0, hazard_o}, 64'd1);
    chk("haz_n1_rd", {59'd0, rd_o}, 64'd5);
    step();
    sample();
    chk("haz_n2", {63'd0, hazard_o}, 64'd0);
    chk("haz_readback_x5", m_regs[5], 64'h7766554433221100);

    // x0 write accepted but never written.
    step();
    ra_i = 5'd0; rb_i = 5'd0;
    ld_valid_i = 1'b1; ld_rd_i = 5'd0; ld_dat_i = 64'hDEADBEEFDEADBEEF;
    sample();
    chk("x0_ld_ready", {63'd0, ld_ready_o}, 64'd1);
    step();
    ld_valid_i = 1'b0;
    sample();
    chk("x0_rwe", {63'd0, rwe_o}, 64'd0);
    chk("x0_hazard", {63'd0, hazard_o}, 64'd0);

    // Set and clear of x7 in the same cycle: set wins.
    step();
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd7;
    step();
    ld_issue_i = 1'b0;
    ld_valid_i = 1'b1; ld_rd_i = 5'd7; ld_dat_i = 64'h0707070707070707;
    step();
    ld_valid_i = 1'b0;
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd7;
    sample();
    chk("coll_rwe", {63'd0, rwe_o}, 64'd1);
    step();
    ld_issue_i = 1'b0; rb_i = 5'd7;
    sample();
    chk("coll_pend7", {63'd0, hazard_o}, 64'd1);

    // Reset in the middle of a write.
    step();
    rb_i = 5'd0;
    ld_issue_i = 1'b1; ld_issue_rd_i = 5'd10; ra_i = 5'd10;
    step();
    ld_issue_i = 1'b0;
    ex_valid_i = 1'b1; ex_rd_i = 5'd9; ex_dat_i = 64'h0909090909090909;
    step();
    ex_valid_i = 1'b0;
    sample();
    chk("mid_rwe_before", {63'd0, rwe_o}, 64'd1);
    chk("mid_haz_before", {63'd0, hazard_o}, 64'd1);
    reset_ni = 1'b0;
    #1;
    chk("mid_rwe_after", {63'd0, rwe_o}, 64'd0);
    chk("mid_haz_after", {63'd0, hazard_o}, 64'd0);
    step();
    step();
    reset_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("post_rst_rwe", {63'd0, rwe_o}, 64'd0);
      chk("post_rst_haz", {63'd0, hazard_o}, 64'd0);
      step();
    end

    // Mixed traffic checked by the model alone.
    for (int i = 0; i < 24; i++) begin
      ex_valid_i    = i[0];
      ld_valid_i    = i[1] ^ i[3];
      ex_rd_i       = 5'(i + 1);
      ld_rd_i       = 5'(i + 3);
      ex_dat_i      = 64'(i) * 64'h0101010101010101;
      ld_dat_i      = ~(64'(i) * 64'h0001000100010001);
      ld_issue_i    = i[2];
      ld_issue_rd_i = 5'(i + 4);
      ra_i          = 5'(i + 3);
      rb_i          = 5'(i + 2);
      step();
    end
    ex_valid_i = 1'b0; ld_valid_i = 1'b0; ld_issue_i = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
